mop_rule_loader: RTL
====================

MOP_RULE_LOADER -- requirements
Module: mop_rule_loader

Interface
REQ-001 SHALL have parameter NB_PERIPH, default 16: width of load_ctrl.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two: entry buffer depth.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port instrut_value, input, 8: instruction byte stream.
REQ-006 SHALL have port instrut_valid_i, input, 1: byte valid.
REQ-007 SHALL have port instrut_ready_o, output, 1: byte accepted when valid and ready are both high.
REQ-008 SHALL have port load_ctrl, input, NB_PERIPH: per-peripheral load enable.
REQ-009 SHALL have port id, input, $clog2(NB_PERIPH): selects this block's load_ctrl bit.
REQ-010 SHALL have port ext_ready_i, input, 1: downstream able to take a write this cycle.
REQ-011 SHALL have port ext_wr, output, 1: single-cycle write strobe to the rule table.
REQ-012 SHALL have port ext_addr, output, 3: rule table address.
REQ-013 SHALL have port ext_data_in, output, 17: rule word.
REQ-014 SHALL have ports err_o (1, sticky frame error), err_clr_i (1, clears err_o), busy_o (1), frame_cnt_o (8, frames committed).

Function
REQ-015 SHALL accept bytes only while load_ctrl[id]=1; instrut_ready_o=0 otherwise.
REQ-016 SHALL parse frames: byte0={addr[2:0],rsvd[3:0],data[16]}, byte1=data[15:8], byte2=data[7:0].
REQ-017 SHALL use FSM S_HDR->S_MID->S_LOW->S_HDR, one transition per accepted byte.
REQ-018 SHALL, on byte0 with rsvd!=0, set err_o and go S_SKIP1->S_SKIP2->S_HDR, discarding the next two bytes; no FIFO push.
REQ-019 SHALL push {addr,data} into the FIFO on byte2 acceptance and increment frame_cnt_o, wrapping 255->0.
REQ-020 SHALL drive instrut_ready_o=0 in the final-byte state while FIFO is full; no same-cycle pass-through on a full FIFO.
REQ-021 SHALL, when load_ctrl[id] falls mid-frame, return to S_HDR next cycle and discard the partial frame; FIFO contents are kept and drained.
REQ-022 SHALL pop one entry per cycle when FIFO is non-empty and ext_ready_i=1, driving ext_wr=1 with ext_addr/ext_data_in registered the following cycle.
REQ-023 SHALL give latency of exactly 2 cycles from last-byte acceptance edge to ext_wr high, given an empty FIFO and ext_ready_i=1.
REQ-024 SHALL hold ext_addr/ext_data_in at their last values while ext_wr=0.
REQ-025 SHALL allow a simultaneous push and pop on a non-full FIFO; occupancy is unchanged.
REQ-026 SHALL give err_clr_i priority below a same-cycle new error (err_o stays 1).
REQ-027 SHALL drive busy_o=1 when FSM!=S_HDR or FIFO non-empty or ext_wr=1.

Reset
REQ-028 SHALL, on rst_ni low, asynchronously clear FSM to S_HDR, empty FIFO, and drive ext_wr=0, ext_addr=0, ext_data_in=0, err_o=0, frame_cnt_o=0, busy_o=0, instrut_ready_o=0.
REQ-029 SHALL discard any in-flight frame and buffered entries on reset mid-operation.

Configuration
REQ-030 SHALL, with MOP_RULE_LOADER_PARITY_EN defined, expect a fourth byte per frame equal to byte0^byte1^byte2 (state S_PAR); on mismatch set err_o and drop the frame without push or count.
REQ-031 SHALL, without MOP_RULE_LOADER_PARITY_EN, use 3-byte frames and have no S_PAR state.

Structure
REQ-032 SHALL place FSM state enum, field positions, RULE_ADDR_W=3, RULE_DATA_W=17 and the entry struct in package mop_rule_loader_pkg.
REQ-033 SHALL implement the buffer as sub-module mop_rule_loader_fifo (synchronous FIFO, full/empty flags, same async reset).

Verification
REQ-034 SHALL check: load_ctrl[id]=1, bytes 0xA1,0x23,0x45, ext_ready_i=1 -> ext_wr one cycle, ext_addr=5, ext_data_in=0x12345, frame_cnt_o=1.
REQ-035 SHALL check: byte0=0x1E (rsvd!=0) then 0xFF,0xFF -> err_o=1, no ext_wr, frame_cnt_o unchanged; err_clr_i pulse -> err_o=0.
REQ-036 SHALL check: ext_ready_i=0, 5 frames -> 4 buffered, instrut_ready_o=0 on frame-5 last byte; ext_ready_i=1 -> 5 writes in order.
REQ-037 SHALL check: load_ctrl[id] dropped after byte1 -> FSM S_HDR, no write; next full frame writes correctly.
REQ-038 SHALL check: rst_ni pulsed low mid-frame with 2 entries buffered -> all outputs at reset values, no ext_wr after release.
REQ-039 SHALL check, with parity enabled: 0xA1,0x23,0x45,0xC7 -> write; parity byte 0x00 -> err_o=1, no write.

Source files
------------

// File: rtl/mop_rule_loader_pkg.sv
// Shared types and constants for the rule loader: frame field positions,
// rule entry layout and the parser state encoding.
// Optional feature macro: MOP_RULE_LOADER_PARITY_EN (adds the S_PAR state).
package mop_rule_loader_pkg;

  localparam int RULE_ADDR_W = 3;
  localparam int RULE_DATA_W = 17;

  // Header byte layout: {addr[2:0], rsvd[3:0], data[16]}
  localparam int HDR_ADDR_MSB = 7;
  localparam int HDR_ADDR_LSB = 5;
  localparam int HDR_RSVD_MSB = 4;
  localparam int HDR_RSVD_LSB = 1;
  localparam int HDR_D16_BIT  = 0;

  typedef enum logic [2:0] {
    S_HDR,
    S_MID,
    S_LOW,
    S_SKIP1,
    S_SKIP2
`ifdef MOP_RULE_LOADER_PARITY_EN
    ,
    S_PAR
`endif
  } state_t;

  typedef struct packed {
    logic [RULE_ADDR_W-1:0] addr;
    logic [RULE_DATA_W-1:0] data;
  } rule_entry_t;

endpackage

// File: rtl/mop_rule_loader_fifo.sv
// Purpose: small synchronous FIFO buffering parsed rule entries.
// Latency: a push is visible at rd_dat/empty the cycle after it is written.
// Backpressure: push is dropped when full, pop is ignored when empty;
//   the producer is expected to consult full before pushing.
// Ports: clk_i, rst_ni (async active-low), push_vld/push_dat, pop_vld,
//   rd_dat (head entry), full, empty.
module mop_rule_loader_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_vld && !full;
  assign do_pop  = pop_vld && !empty;
  assign rd_dat  = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/mop_rule_loader.sv
// Purpose: parses a byte stream of rule frames and writes {addr,data} into an external rule table.
// Latency: 2 cycles from last-byte acceptance to ext_wr (empty buffer, ext_ready_i high).
// Backpressure: instrut_ready_o drops while not enabled, or on the final byte while the buffer is full.
// Ports: clk_i/rst_ni (async active-low); instrut_value/_valid_i/_ready_o byte stream;
//   load_ctrl[id] enable; ext_ready_i/ext_wr/ext_addr/ext_data_in table write;
//   err_o/err_clr_i sticky frame error; busy_o; frame_cnt_o committed frame count.
// Build option: MOP_RULE_LOADER_PARITY_EN adds a fourth XOR-parity byte per frame.
module mop_rule_loader
  import mop_rule_loader_pkg::*;
#(
  parameter int NB_PERIPH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [7:0]                   instrut_value,
  input  logic                         instrut_valid_i,
  output logic                         instrut_ready_o,
  input  logic [NB_PERIPH-1:0]         load_ctrl,
  input  logic [$clog2(NB_PERIPH)-1:0] id,
  input  logic                         ext_ready_i,
  output logic                         ext_wr,
  output logic [RULE_ADDR_W-1:0]       ext_addr,
  output logic [RULE_DATA_W-1:0]       ext_data_in,
  output logic                         err_o,
  input  logic                         err_clr_i,
  output logic                         busy_o,
  output logic [7:0]                   frame_cnt_o
);

`ifdef MOP_RULE_LOADER_PARITY_EN
  localparam state_t FINAL_ST = S_PAR;
`else
  localparam state_t FINAL_ST = S_LOW;
`endif

  state_t                  state_q, state_d;
  logic                    en;
  logic                    accept;
  logic                    rdy_arm_q;
  logic                    frame_done;
  logic                    err_set;
  logic [RULE_ADDR_W-1:0]  addr_q;
  logic                    d16_q;
  logic [7:0]              mid_q;
  logic [7:0]              low_byte;
  rule_entry_t             new_entry;
  logic                    push_vld_q;
  rule_entry_t             push_dat_q;
  rule_entry_t             fifo_rd;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop;
  logic                    ext_wr_q;
  logic [RULE_ADDR_W-1:0]  ext_addr_q;
  logic [RULE_DATA_W-1:0]  ext_data_q;
  logic                    err_q;
  logic [7:0]              frame_cnt_q;
`ifdef MOP_RULE_LOADER_PARITY_EN
  logic [7:0]              low_q;
  logic [7:0]              par_q;
`endif

  assign en = load_ctrl[id];

  // rdy_arm_q keeps ready low during reset and for the first cycle after release.
  assign instrut_ready_o = rdy_arm_q && en && !((state_q == FINAL_ST) && fifo_full);
  assign accept          = instrut_valid_i && instrut_ready_o;

`ifdef MOP_RULE_LOADER_PARITY_EN
  assign low_byte = low_q;
`else
  assign low_byte = instrut_value;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_HDR;
      rdy_arm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_arm_q <= 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    frame_done     = 1'b0;
    err_set        = 1'b0;
    new_entry.addr = addr_q;
    new_entry.data = {d16_q, mid_q, low_byte};
    if (!en) begin
      // Enable withdrawn: abandon any partial frame.
      state_d = S_HDR;
    end else if (accept) begin
      case (state_q)
        S_HDR: begin
          if (instrut_value[HDR_RSVD_MSB:HDR_RSVD_LSB] != '0) begin
            err_set = 1'b1;
            state_d = S_SKIP1;
          end else begin
            state_d = S_MID;
          end
        end
        S_MID:   state_d = S_LOW;
`ifdef MOP_RULE_LOADER_PARITY_EN
        S_LOW:   state_d = S_PAR;
        S_PAR: begin
          state_d = S_HDR;
          if (instrut_value == par_q) frame_done = 1'b1;
          else                        err_set    = 1'b1;
        end
`else
        S_LOW: begin
          state_d    = S_HDR;
          frame_done = 1'b1;
        end
`endif
        S_SKIP1: state_d = S_SKIP2;
        S_SKIP2: state_d = S_HDR;
        default: state_d = S_HDR;
      endcase
    end
  end

  // Field capture as bytes are accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      d16_q  <= 1'b0;
      mid_q  <= '0;
`ifdef MOP_RULE_LOADER_PARITY_EN
      low_q  <= '0;
      par_q  <= '0;
`endif
    end else if (accept) begin
      case (state_q)
        S_HDR: begin
          addr_q <= instrut_value[HDR_ADDR_MSB:HDR_ADDR_LSB];
          d16_q  <= instrut_value[HDR_D16_BIT];
`ifdef MOP_RULE_LOADER_PARITY_EN
          par_q  <= instrut_value;
`endif
        end
        S_MID: begin
          mid_q <= instrut_value;
`ifdef MOP_RULE_LOADER_PARITY_EN
          par_q <= par_q ^ instrut_value;
`endif
        end
`ifdef MOP_RULE_LOADER_PARITY_EN
        S_LOW: begin
          low_q <= instrut_value;
          par_q <= par_q ^ instrut_value;
        end
`endif
        default: ;
      endcase
    end
  end

  // Completed frames are registered once before entering the buffer; this
  // stage is what sets the two-cycle acceptance-to-write latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      push_vld_q  <= 1'b0;
      push_dat_q  <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      push_vld_q <= frame_done;
      if (frame_done) begin
        push_dat_q  <= new_entry;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
      // A new error wins over a same-cycle clear.
      if (err_set)        err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;
    end
  end

  mop_rule_loader_fifo #(
    .WIDTH ($bits(rule_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_vld (push_vld_q),
    .push_dat (push_dat_q),
    .pop_vld  (pop),
    .rd_dat   (fifo_rd),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign pop = !fifo_empty && ext_ready_i;

  // Address/data only move on a write, so they hold between strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ext_wr_q   <= 1'b0;
      ext_addr_q <= '0;
      ext_data_q <= '0;
    end else begin
      ext_wr_q <= pop;
      if (pop) begin
        ext_addr_q <= fifo_rd.addr;
        ext_data_q <= fifo_rd.data;
      end
    end
  end

  assign ext_wr      = ext_wr_q;
  assign ext_addr    = ext_addr_q;
  assign ext_data_in = ext_data_q;
  assign err_o       = err_q;
  assign frame_cnt_o = frame_cnt_q;
  assign busy_o      = (state_q != S_HDR) || push_vld_q || !fifo_empty || ext_wr_q;

endmodule
